bankgroup_arbiter: RTL and testbench

- Shares one bankgroup SRAM port between N_REQ requesters with round-robin arbitration.
- Issues at most one read or write per cycle and drives registered en/we/re/addr/din into the bankgroup.
- Tracks in-flight reads in a latency-matched tag pipe and routes returned data to the requester that issued the read.
- Sits between the compute-side clients (PE / DMA ports) and a single bankgroup instance.

---
 rtl/bankgroup_arbiter_pkg.sv | 13 +
 rtl/bankgroup_arbiter_rr_arbiter.sv | 29 ++
 rtl/bankgroup_arbiter.sv | 91 +++++++++
 tb/tb_bankgroup_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bankgroup_arbiter_pkg.sv
// bankgroup_arbiter_pkg: shared bankgroup parameters and round-robin helper
package bankgroup_arbiter_pkg;
    localparam int BG_A_W      = 16;
    localparam int BG_D_W      = 32;
    localparam int BG_C_L_MARK = BG_D_W;
    localparam int BG_C_L_BUS  = BG_C_L_MARK + 1;
    localparam int BG_N_REQ    = 4;
    localparam int BG_RD_LAT   = 2;

    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/bankgroup_arbiter_rr_arbiter.sv
// bankgroup_arbiter_rr_arbiter: N-way round-robin one-hot grant starting at ptr
module bankgroup_arbiter_rr_arbiter #(
    parameter int N   = 4,
    parameter int P_W = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [P_W-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [P_W-1:0] gnt_idx
);
    logic found;
    int   j;

    // first active request at or after ptr, wrapping around
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found      = 1'b1;
                gnt[j]     = 1'b1;
                gnt_idx    = P_W'(j);
            end
        end
    end
endmodule

// File: rtl/bankgroup_arbiter.sv
// bankgroup_arbiter: round-robin sharing of one bankgroup SRAM port with read return routing
module bankgroup_arbiter
    import bankgroup_arbiter_pkg::*;
#(
    parameter int N_REQ  = BG_N_REQ,
    parameter int A_W    = BG_A_W,
    parameter int D_W    = BG_D_W,
    parameter int C_L_W  = BG_C_L_BUS,
    parameter int RD_LAT = BG_RD_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_we,
    input  logic [N_REQ*A_W-1:0] req_addr,
    input  logic [N_REQ*D_W-1:0] req_wdata,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [D_W-1:0]     rsp_rdata,
    output logic               bg_en_o,
    output logic               bg_we_o,
    output logic               bg_re_o,
    output logic [A_W-1:0]     bg_addr_o,
    output logic [D_W-1:0]     bg_din_o,
    input  logic [C_L_W-1:0]   bg_dout_bus_i,
    output logic               err_marker
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]  gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   bg_id;
    logic [RD_LAT-1:0] tag_vld;
    logic [ID_W-1:0]   tag_id [RD_LAT];
    logic              hs;
    logic              tail;

    bankgroup_arbiter_rr_arbiter #(.N(N_REQ), .P_W(ID_W)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = rst ? '0 : gnt;
    assign hs        = |req_ready;
    assign tail      = tag_vld[RD_LAT-1];
    assign rsp_valid = tail ? (N_REQ'(1) << tag_id[RD_LAT-1]) : '0;
    assign rsp_rdata = tail ? bg_dout_bus_i[D_W-1:0] : '0;

    // issue register and pointer advance on each handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            bg_en_o   <= 1'b0;
            bg_we_o   <= 1'b0;
            bg_re_o   <= 1'b0;
            bg_addr_o <= '0;
            bg_din_o  <= '0;
            bg_id     <= '0;
        end else begin
            bg_en_o <= hs;
            bg_we_o <= hs & req_we[gnt_idx];
            bg_re_o <= hs & ~req_we[gnt_idx];
            if (hs) begin
                rr_ptr    <= ID_W'(rr_next(int'(gnt_idx), N_REQ));
                bg_addr_o <= req_addr[int'(gnt_idx)*A_W +: A_W];
                bg_din_o  <= req_wdata[int'(gnt_idx)*D_W +: D_W];
                bg_id     <= gnt_idx;
            end
        end
    end

    // tag pipe follows the bankgroup read latency; marker error is sticky
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld    <= '0;
            err_marker <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) tag_id[k] <= '0;
        end else begin
            tag_vld[0] <= bg_re_o;
            tag_id[0]  <= bg_id;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
            err_marker <= err_marker | (tail & ~bg_dout_bus_i[C_L_W-1]);
        end
    end
endmodule

// File: tb/tb_bankgroup_arbiter.sv
// tb_bankgroup_arbiter: directed checks of arbitration, issue, read return and marker error
module tb_bankgroup_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_we, req_ready, rsp_valid;
    logic [63:0] req_addr;
    logic [127:0] req_wdata;
    logic [31:0] rsp_rdata, bg_din_o;
    logic        bg_en_o, bg_we_o, bg_re_o, err_marker;
    logic [15:0] bg_addr_o;
    logic [32:0] bg_dout_bus_i;

    logic        preload, kill_marker;
    logic        r_en, r_we, r_re;
    logic [15:0] r_addr;
    logic [31:0] r_din;
    logic [32:0] dout;
    logic [31:0] mem [0:255];

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cnt [4];

    bankgroup_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .bg_en_o       (bg_en_o),
        .bg_we_o       (bg_we_o),
        .bg_re_o       (bg_re_o),
        .bg_addr_o     (bg_addr_o),
        .bg_din_o      (bg_din_o),
        .bg_dout_bus_i (bg_dout_bus_i),
        .err_marker    (err_marker)
    );

    always #5 clk = ~clk;

    // bankgroup model: input register then SRAM read register
    always @(posedge clk) begin
        if (preload) begin
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h00] <= 32'h1000_0000;
            mem[8'h01] <= 32'h1111_0001;
            mem[8'h02] <= 32'h2222_0002;
            mem[8'h03] <= 32'h3333_0003;
            dout       <= '0;
            r_en       <= 1'b0;
        end else begin
            r_en   <= bg_en_o;
            r_we   <= bg_we_o;
            r_re   <= bg_re_o;
            r_addr <= bg_addr_o;
            r_din  <= bg_din_o;
            if (r_en && r_we) mem[r_addr[7:0]] <= r_din;
            if (r_en && r_re) dout <= {1'b1, mem[r_addr[7:0]]};
        end
    end

    assign bg_dout_bus_i = {dout[32] & ~kill_marker, dout[31:0]};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic we, input logic [15:0] a, input logic [31:0] d);
        req_valid[i]         = 1'b1;
        req_we[i]            = we;
        req_addr[i*16 +: 16] = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic clr_req();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1; kill_marker = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        tick();
        tick();
        preload = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("ready_in_reset", req_ready, 4'b0000);
        chk("rst_en", bg_en_o, 1'b0);
        chk("rst_addr", bg_addr_o, 16'h0);
        chk("rst_din", bg_din_o, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_err", err_marker, 1'b0);
        clr_req();
        rst = 1'b0;
        #1;

        // single read
        set_req(0, 1'b0, 16'h0010, 32'h0);
        #1;
        chk("rd_ready", req_ready, 4'b0001);
        tick();
        clr_req();
        chk("rd_en", bg_en_o, 1'b1);
        chk("rd_re", bg_re_o, 1'b1);
        chk("rd_we", bg_we_o, 1'b0);
        chk("rd_addr", bg_addr_o, 16'h0010);
        chk("rd_rsp_c1", rsp_valid, 4'b0000);
        tick();
        chk("rd_rsp_c2", rsp_valid, 4'b0000);
        tick();
        chk("rd_rsp_valid", rsp_valid, 4'b0001);
        chk("rd_rsp_data", rsp_rdata, 32'hDEADBEEF);
        tick();
        chk("rd_rsp_after", rsp_valid, 4'b0000);
        chk("rd_en_idle", bg_en_o, 1'b0);
        chk("rd_addr_hold", bg_addr_o, 16'h0010);
        chk("rd_rdata_idle", rsp_rdata, 32'h0);

        // fairness with all requesters valid from ptr 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b0, 16'(i), 32'h0);
            cnt[i] = 0;
        end
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("fair_gnt%0d", k), req_ready, 4'b0001 << (k % 4));
            for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
            tick();
        end
        clr_req();
        for (int i = 0; i < 4; i++) chk($sformatf("fair_cnt%0d", i), 64'(cnt[i]), 64'd2);
        tick(); tick(); tick(); tick();

        // write then read same address
        set_req(2, 1'b1, 16'h0020, 32'hA5A5_0001);
        #1;
        chk("wr_ready", req_ready, 4'b0100);
        tick();
        clr_req();
        chk("wr_we", bg_we_o, 1'b1);
        chk("wr_re", bg_re_o, 1'b0);
        chk("wr_addr", bg_addr_o, 16'h0020);
        chk("wr_din", bg_din_o, 32'hA5A5_0001);
        set_req(1, 1'b0, 16'h0020, 32'h0);
        #1;
        chk("raw_ready", req_ready, 4'b0010);
        tick();
        clr_req();
        chk("raw_re", bg_re_o, 1'b1);
        tick();
        chk("wr_no_rsp", rsp_valid, 4'b0000);
        tick();
        chk("raw_rsp_valid", rsp_valid, 4'b0010);
        chk("raw_rsp_data", rsp_rdata, 32'hA5A5_0001);
        tick();
        chk("raw_rsp_after", rsp_valid, 4'b0000);

        // pipelined reads from different requesters
        set_req(0, 1'b0, 16'h0000, 32'h0);
        #1;
        chk("pipe_ready0", req_ready, 4'b0001);
        tick();
        clr_req();
        set_req(3, 1'b0, 16'h0001, 32'h0);
        #1;
        chk("pipe_ready3", req_ready, 4'b1000);
        tick();
        clr_req();
        set_req(1, 1'b0, 16'h0002, 32'h0);
        #1;
        chk("pipe_ready1", req_ready, 4'b0010);
        tick();
        clr_req();
        chk("pipe_rsp0", rsp_valid, 4'b0001);
        chk("pipe_dat0", rsp_rdata, 32'h1000_0000);
        tick();
        chk("pipe_rsp3", rsp_valid, 4'b1000);
        chk("pipe_dat3", rsp_rdata, 32'h1111_0001);
        tick();
        chk("pipe_rsp1", rsp_valid, 4'b0010);
        chk("pipe_dat1", rsp_rdata, 32'h2222_0002);
        tick();
        chk("pipe_idle", rsp_valid, 4'b0000);

        // reset while reads are in flight
        set_req(0, 1'b0, 16'h0010, 32'h0);
        tick();
        clr_req();
        set_req(1, 1'b0, 16'h0000, 32'h0);
        tick();
        clr_req();
        rst = 1'b1;
        #1;
        chk("mid_en", bg_en_o, 1'b0);
        chk("mid_re", bg_re_o, 1'b0);
        chk("mid_addr", bg_addr_o, 16'h0);
        chk("mid_rsp", rsp_valid, 4'b0000);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mid_norsp%0d", k), rsp_valid, 4'b0000);
            tick();
        end
        req_valid = 4'b1111;
        #1;
        chk("mid_ptr0", req_ready, 4'b0001);
        clr_req();
        #1;

        // marker check: idle tail ignores marker, valid tail flags it
        kill_marker = 1'b1;
        tick(); tick(); tick();
        chk("mark_idle", err_marker, 1'b0);
        set_req(2, 1'b0, 16'h0010, 32'h0);
        #1;
        chk("mark_ready", req_ready, 4'b0100);
        tick();
        clr_req();
        tick();
        tick();
        chk("mark_rsp", rsp_valid, 4'b0100);
        chk("mark_dat", rsp_rdata, 32'hDEADBEEF);
        chk("mark_pre", err_marker, 1'b0);
        tick();
        chk("mark_set", err_marker, 1'b1);
        kill_marker = 1'b0;
        tick(); tick();
        chk("mark_sticky", err_marker, 1'b1);
        do_reset();
        chk("mark_clr", err_marker, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
